// File: rtl/rom_load_pkg.sv
// Shared types and defaults for the game ROM download/fetch arbiter.
package rom_load_pkg;

    localparam int ROM_AW          = 16;
    localparam int DEF_ROM_SIZE    = 32'h2000;
    localparam int DEF_HOLD_CYCLES = 16;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        DL   = 2'd1,
        HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic [ROM_AW-1:0] addr;
        logic [7:0]        data;
    } rom_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with extra-bit pointers and a flush input.
module sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PW = $clog2(DEPTH);

    logic [PW:0]      wr_ptr;
    logic [PW:0]      rd_ptr;
    logic [WIDTH-1:0] slots [DEPTH];
    logic             do_push;
    logic             do_pop;

    // Same slot index with differing wrap bits means every slot is occupied.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = slots[rd_ptr[PW-1:0]];

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) slots[wr_ptr[PW-1:0]] <= push_data;
    end

endmodule

// File: rtl/rom_load_arbiter.sv
// Shares the game ROM RAM port between the HPS download writer and the core's
// fetch reader, and holds the core in reset around each download.
module rom_load_arbiter
    import rom_load_pkg::*;
#(
    parameter int AW          = ROM_AW,
    parameter int ROM_SIZE    = DEF_ROM_SIZE,
    parameter int FIFO_DEPTH  = 4,
    parameter int HOLD_CYCLES = DEF_HOLD_CYCLES
) (
    input  logic          clk_25,
    input  logic          reset,
    input  logic          ioctl_download,
    input  logic          ioctl_wr,
    input  logic [AW-1:0] ioctl_addr,
    input  logic [7:0]    ioctl_dout,
    input  logic          rd_req,
    input  logic [AW-1:0] rd_addr,
    output logic          rd_ack,
    output logic          rd_valid,
    output logic [7:0]    rd_data,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_din,
    output logic          mem_we,
    input  logic [7:0]    mem_dout,
    output logic          core_reset,
    output logic [7:0]    dl_sum,
    output logic [AW:0]   dl_count,
    output logic          dl_drop
);

    localparam int              EW        = AW + 8;
    localparam int              CW        = $clog2(HOLD_CYCLES + 1);
    localparam logic [AW:0]     ROM_LIMIT = (AW+1)'(ROM_SIZE);
    localparam logic [CW-1:0]   HOLD_LOAD = CW'(HOLD_CYCLES);

    state_t          state;
    state_t          state_nx;
    logic [CW-1:0]   hold_cnt;
    logic            dl_entry;
    logic            wr_seen;
    logic            in_range;
    logic            accept;
    logic            pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [EW-1:0]   head;
    logic            wr_vld_p1;
    logic [AW-1:0]   wr_addr_p1;

    function automatic logic [AW:0] sat_inc(input logic [AW:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    always_comb begin
        state_nx = state;
        case (state)
            RUN:     if (ioctl_download) state_nx = DL;
            DL:      if (!ioctl_download && fifo_empty) state_nx = HOLD;
            HOLD: begin
                if (ioctl_download)              state_nx = DL;
                else if (hold_cnt <= CW'(1))     state_nx = RUN;
            end
            default: state_nx = HOLD;
        endcase
    end

    assign dl_entry = (state != DL) && (state_nx == DL);
    assign wr_seen  = (state == DL) && ioctl_wr;
    assign in_range = ({1'b0, ioctl_addr} < ROM_LIMIT);
    // Full is judged before this cycle's pop, so a full FIFO never takes a byte.
    assign accept   = wr_seen && in_range && !fifo_full;
    assign pop      = !fifo_empty && !dl_entry;

    // The writer owns the port while anything is buffered or a write is landing.
    assign rd_ack   = !reset && rd_req && fifo_empty && !wr_vld_p1;
    assign mem_addr = rd_ack ? rd_addr : wr_addr_p1;
    assign mem_we   = wr_vld_p1;
    assign rd_data  = rd_valid ? mem_dout : 8'h00;

    sync_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (EW)
    ) u_fifo (
        .clk       (clk_25),
        .reset     (reset),
        .flush     (dl_entry),
        .push      (accept),
        .push_data ({ioctl_addr, ioctl_dout}),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Stage p1: popped entry drives the RAM write port.
    always_ff @(posedge clk_25) begin
        if (reset) begin
            state      <= HOLD;
            hold_cnt   <= HOLD_LOAD;
            core_reset <= 1'b1;
            wr_vld_p1  <= 1'b0;
            wr_addr_p1 <= '0;
            mem_din    <= 8'h00;
            rd_valid   <= 1'b0;
            dl_sum     <= 8'h00;
            dl_count   <= '0;
            dl_drop    <= 1'b0;
        end else begin
            state      <= state_nx;
            core_reset <= (state_nx != RUN);

            if (state != HOLD && state_nx == HOLD)
                hold_cnt <= HOLD_LOAD;
            else if (state == HOLD && hold_cnt != '0)
                hold_cnt <= hold_cnt - 1'b1;

            wr_vld_p1 <= pop;
            if (pop) begin
                wr_addr_p1 <= head[EW-1:8];
                mem_din    <= head[7:0];
            end

            rd_valid <= rd_ack;

            if (dl_entry) begin
                dl_sum   <= 8'h00;
                dl_count <= '0;
                dl_drop  <= 1'b0;
            end else begin
                if (accept) begin
                    dl_count <= sat_inc(dl_count);
                    dl_sum   <= dl_sum + ioctl_dout;
                end
                if (wr_seen && !accept) dl_drop <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_rom_load_arbiter.sv
// Directed bench for rom_load_arbiter with a one-cycle-latency RAM model.
module tb_rom_load_arbiter;

    localparam int AW = 16;

    logic          clk_25 = 1'b0;
    logic          reset;
    logic          ioctl_download;
    logic          ioctl_wr;
    logic [AW-1:0] ioctl_addr;
    logic [7:0]    ioctl_dout;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic          rd_valid;
    logic [7:0]    rd_data;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_din;
    logic          mem_we;
    logic [7:0]    mem_dout;
    logic          core_reset;
    logic [7:0]    dl_sum;
    logic [AW:0]   dl_count;
    logic          dl_drop;

    logic [7:0]    ram [0:65535];
    int            n_cmp = 0;
    int            n_err = 0;
    int            ones;

    rom_load_arbiter #(
        .AW          (AW),
        .ROM_SIZE    (32'h2000),
        .FIFO_DEPTH  (4),
        .HOLD_CYCLES (16)
    ) dut (
        .clk_25         (clk_25),
        .reset          (reset),
        .ioctl_download (ioctl_download),
        .ioctl_wr       (ioctl_wr),
        .ioctl_addr     (ioctl_addr),
        .ioctl_dout     (ioctl_dout),
        .rd_req         (rd_req),
        .rd_addr        (rd_addr),
        .rd_ack         (rd_ack),
        .rd_valid       (rd_valid),
        .rd_data        (rd_data),
        .mem_addr       (mem_addr),
        .mem_din        (mem_din),
        .mem_we         (mem_we),
        .mem_dout       (mem_dout),
        .core_reset     (core_reset),
        .dl_sum         (dl_sum),
        .dl_count       (dl_count),
        .dl_drop        (dl_drop)
    );

    always #5 clk_25 = ~clk_25;

    always @(posedge clk_25) begin
        if (mem_we) ram[mem_addr] <= mem_din;
        mem_dout <= ram[mem_addr];
    end

    task automatic tick();
        @(posedge clk_25);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_wr       = 1'b0;
        ioctl_addr     = '0;
        ioctl_dout     = 8'h00;
        rd_req         = 1'b0;
        rd_addr        = '0;

        // Reset values, then a 16-cycle core reset stretch.
        repeat (3) tick();
        reset = 1'b0;
        #1;
        chk("rst_core_reset", core_reset, 1);
        chk("rst_rd_ack", rd_ack, 0);
        chk("rst_rd_valid", rd_valid, 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_din", mem_din, 0);
        chk("rst_dl_sum", dl_sum, 0);
        chk("rst_dl_count", dl_count, 0);
        chk("rst_dl_drop", dl_drop, 0);
        ones = 1;
        for (int i = 0; i < 15; i++) begin
            tick(); #1;
            if (core_reset === 1'b1) ones++;
        end
        chk("hold_len_after_reset", ones, 16);
        tick(); #1;
        chk("hold_release", core_reset, 0);
        chk("hold_release_mem_we", mem_we, 0);

        // Four-byte download followed by an out-of-range byte.
        ioctl_download = 1'b1;
        tick(); #1;
        chk("dl_entry_core_reset", core_reset, 1);
        for (int i = 0; i < 4; i++) begin
            ioctl_wr   = 1'b1;
            ioctl_addr = AW'(i);
            ioctl_dout = 8'(16 * (i + 1));
            tick(); #1;
            if (i >= 1) begin
                chk("dl_write_we", mem_we, 1);
                chk("dl_write_addr", mem_addr, i - 1);
                chk("dl_write_din", mem_din, 16 * i);
            end
        end
        chk("dl_count_4", dl_count, 4);
        chk("dl_sum_a0", dl_sum, 8'hA0);
        chk("dl_drop_clear", dl_drop, 0);
        ioctl_addr     = 16'h2000;
        ioctl_dout     = 8'h55;
        ioctl_download = 1'b0;
        tick();
        ioctl_wr = 1'b0;
        #1;
        chk("dl_last_we", mem_we, 1);
        chk("dl_last_addr", mem_addr, 3);
        chk("dl_last_din", mem_din, 8'h40);
        chk("oor_drop", dl_drop, 1);
        chk("oor_count", dl_count, 4);
        chk("oor_sum", dl_sum, 8'hA0);
        tick(); #1;
        chk("oor_no_write", mem_we, 0);
        chk("post_dl_core_reset", core_reset, 1);
        ones = 0;
        for (int i = 0; i < 15; i++) begin
            tick(); #1;
            if (core_reset === 1'b1) ones++;
        end
        chk("hold_len_after_dl", ones, 15);
        tick(); #1;
        chk("dl_release", core_reset, 0);
        for (int i = 0; i < 4; i++) chk("ram_contents", ram[i], 16 * (i + 1));

        // Back-to-back reads in RUN.
        rd_req  = 1'b1;
        rd_addr = 16'h0003;
        #1;
        chk("rd0_ack", rd_ack, 1);
        chk("rd0_addr", mem_addr, 3);
        chk("rd0_no_valid", rd_valid, 0);
        tick();
        rd_addr = 16'h0001;
        #1;
        chk("rd0_valid", rd_valid, 1);
        chk("rd0_data", rd_data, 8'h40);
        chk("rd1_ack", rd_ack, 1);
        chk("rd1_addr", mem_addr, 1);
        tick();
        rd_addr = 16'h0002;
        #1;
        chk("rd1_valid", rd_valid, 1);
        chk("rd1_data", rd_data, 8'h20);
        chk("rd2_ack", rd_ack, 1);
        tick();
        rd_req = 1'b0;
        #1;
        chk("rd2_valid", rd_valid, 1);
        chk("rd2_data", rd_data, 8'h30);
        chk("rd_idle_ack", rd_ack, 0);
        tick(); #1;
        chk("rd_idle_valid", rd_valid, 0);
        chk("rd_idle_data", rd_data, 0);

        // Buffered writes take the port ahead of a pending read.
        ioctl_download = 1'b1;
        tick(); #1;
        chk("dl2_core_reset", core_reset, 1);
        chk("dl2_drop_cleared", dl_drop, 0);
        chk("dl2_count_cleared", dl_count, 0);
        chk("dl2_sum_cleared", dl_sum, 0);
        ioctl_wr   = 1'b1;
        ioctl_addr = 16'h0000;
        ioctl_dout = 8'hAA;
        tick();
        ioctl_addr = 16'h0001;
        ioctl_dout = 8'hBB;
        rd_req     = 1'b1;
        rd_addr    = 16'h0001;
        #1;
        chk("prio_c1_ack", rd_ack, 0);
        tick();
        ioctl_wr = 1'b0;
        #1;
        chk("prio_c2_we", mem_we, 1);
        chk("prio_c2_addr", mem_addr, 0);
        chk("prio_c2_din", mem_din, 8'hAA);
        chk("prio_c2_ack", rd_ack, 0);
        tick(); #1;
        chk("prio_c3_we", mem_we, 1);
        chk("prio_c3_addr", mem_addr, 1);
        chk("prio_c3_din", mem_din, 8'hBB);
        chk("prio_c3_ack", rd_ack, 0);
        tick(); #1;
        chk("prio_c4_we", mem_we, 0);
        chk("prio_c4_ack", rd_ack, 1);
        chk("prio_c4_addr", mem_addr, 1);
        tick();
        rd_req = 1'b0;
        #1;
        chk("prio_valid", rd_valid, 1);
        chk("prio_data", rd_data, 8'hBB);
        chk("prio_count", dl_count, 2);
        chk("prio_sum_wrap", dl_sum, 8'h65);
        chk("prio_core_reset", core_reset, 1);

        // Download reasserted during HOLD.
        ioctl_download = 1'b0;
        tick(); #1;
        chk("hold2_core_reset", core_reset, 1);
        repeat (3) tick();
        #1;
        chk("hold2_count_kept", dl_count, 2);
        chk("hold2_core_reset_mid", core_reset, 1);
        ioctl_download = 1'b1;
        tick(); #1;
        chk("redl_core_reset", core_reset, 1);
        chk("redl_count", dl_count, 0);
        chk("redl_sum", dl_sum, 0);

        // Last in-range address, then reset with the byte still buffered.
        ioctl_wr   = 1'b1;
        ioctl_addr = 16'h1FFF;
        ioctl_dout = 8'h01;
        tick();
        ioctl_wr = 1'b0;
        #1;
        chk("edge_count", dl_count, 1);
        chk("edge_sum", dl_sum, 1);
        chk("edge_drop", dl_drop, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        chk("midrst_we", mem_we, 0);
        chk("midrst_count", dl_count, 0);
        chk("midrst_core_reset", core_reset, 1);
        tick(); #1;
        chk("midrst_flushed", mem_we, 0);
        chk("midrst_redl_core_reset", core_reset, 1);
        ioctl_download = 1'b0;
        tick(); #1;
        chk("midrst_still_flushed", mem_we, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
